// File: rtl/dct_postfft_twiddle.sv
// Post-FFT rotation stage of the DCT path: Y[k] = X[k] * exp(-j*pi*k/2N), twiddles from a 1-cycle ROM.
// Four pipeline stages (capture, ROM align, multiply, sum/round/saturate) with a global output stall.
module dct_postfft_twiddle #(
    parameter int wDataInOut = 16,
    parameter int wTw        = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         sink_valid,
    output logic                         sink_ready,
    input  logic [1:0]                   sink_error,
    input  logic                         sink_sop,
    input  logic                         sink_eop,
    input  logic signed [wDataInOut-1:0] sink_real,
    input  logic signed [wDataInOut-1:0] sink_imag,
    input  logic [11:0]                  fftpts_in,
    output logic [10:0]                  tw_addr,
    input  logic signed [wTw-1:0]        tw_cos,
    input  logic signed [wTw-1:0]        tw_sin,
    output logic                         source_valid,
    input  logic                         source_ready,
    output logic [1:0]                   source_error,
    output logic                         source_sop,
    output logic                         source_eop,
    output logic signed [wDataInOut-1:0] source_real,
    output logic signed [wDataInOut-1:0] source_imag,
    output logic [11:0]                  fftpts_out
);
    localparam int PW = wDataInOut + wTw;
    localparam int SW = PW + 1;
    localparam logic signed [SW-1:0] RND  = SW'(64'sd1 <<< (wTw - 2));
    localparam logic signed [SW-1:0] MAXV = SW'((64'sd1 <<< (wDataInOut - 1)) - 64'sd1);
    localparam logic signed [SW-1:0] MINV = SW'(-(64'sd1 <<< (wDataInOut - 1)));

    logic                         stall, accept, atLast, wrapD, wrapQ;
    logic [10:0]                  kCur, kD, kQ, twAddrQ;
    logic [11:0]                  nEff, fftptsQ;
    logic [1:0]                   errIn;
    logic                         s1ValidQ, s1SopQ, s1EopQ;
    logic [1:0]                   s1ErrQ;
    logic signed [wDataInOut-1:0] s1ReQ, s1ImQ;
    logic                         s2ValidQ, s2SopQ, s2EopQ;
    logic [1:0]                   s2ErrQ;
    logic signed [wDataInOut-1:0] s2ReQ, s2ImQ;
    logic                         twFreshQ;
    logic signed [wTw-1:0]        cosHoldQ, sinHoldQ, cosEff, sinEff;
    logic                         s3ValidQ, s3SopQ, s3EopQ;
    logic [1:0]                   s3ErrQ;
    logic signed [PW-1:0]         pRcQ, pIsQ, pIcQ, pRsQ;
    logic signed [SW-1:0]         sumRe, sumIm, rndRe, rndIm;
    logic                         outValidQ, outSopQ, outEopQ;
    logic [1:0]                   outErrQ;
    logic signed [wDataInOut-1:0] outReQ, outImQ;

    function automatic logic signed [wDataInOut-1:0] saturate(input logic signed [SW-1:0] v);
        if (v > MAXV) return MAXV[wDataInOut-1:0];
        if (v < MINV) return MINV[wDataInOut-1:0];
        return v[wDataInOut-1:0];
    endfunction

    always_comb begin
        stall  = outValidQ && !source_ready;
        accept = sink_valid && !stall;
        kCur   = sink_sop ? 11'd0 : kQ;
        nEff   = sink_sop ? fftpts_in : fftptsQ;
        atLast = ({1'b0, kCur} == (nEff - 12'd1));
        kD     = (sink_eop || atLast) ? 11'd0 : kCur + 11'd1;
        wrapD  = atLast && !sink_eop;
        errIn  = sink_error | {1'b0, wrapQ && !sink_sop};
        // After a stall edge the ROM already shows the S1 address, so S2 uses the captured twiddle.
        cosEff = twFreshQ ? tw_cos : cosHoldQ;
        sinEff = twFreshQ ? tw_sin : sinHoldQ;
        sumRe  = SW'(pRcQ) + SW'(pIsQ);
        sumIm  = SW'(pIcQ) - SW'(pRsQ);
        rndRe  = (sumRe + RND) >>> (wTw - 1);
        rndIm  = (sumIm + RND) >>> (wTw - 1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kQ       <= '0;
            wrapQ    <= 1'b0;
            fftptsQ  <= '0;
            twAddrQ  <= '0;
            twFreshQ <= 1'b1;
            cosHoldQ <= '0;
            sinHoldQ <= '0;
        end else begin
            twFreshQ <= !stall;
            if (stall && twFreshQ) begin
                cosHoldQ <= tw_cos;
                sinHoldQ <= tw_sin;
            end
            if (accept) begin
                kQ      <= kD;
                wrapQ   <= wrapD;
                twAddrQ <= kCur;
                if (sink_sop) fftptsQ <= fftpts_in;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1ValidQ <= 1'b0; s1SopQ <= 1'b0; s1EopQ <= 1'b0; s1ErrQ <= '0; s1ReQ <= '0; s1ImQ <= '0;
            s2ValidQ <= 1'b0; s2SopQ <= 1'b0; s2EopQ <= 1'b0; s2ErrQ <= '0; s2ReQ <= '0; s2ImQ <= '0;
            s3ValidQ <= 1'b0; s3SopQ <= 1'b0; s3EopQ <= 1'b0; s3ErrQ <= '0;
            pRcQ <= '0; pIsQ <= '0; pIcQ <= '0; pRsQ <= '0;
            outValidQ <= 1'b0; outSopQ <= 1'b0; outEopQ <= 1'b0; outErrQ <= '0;
            outReQ <= '0; outImQ <= '0;
        end else if (!stall) begin
            s1ValidQ <= accept;
            s1SopQ   <= sink_sop;
            s1EopQ   <= sink_eop;
            s1ErrQ   <= errIn;
            s1ReQ    <= sink_real;
            s1ImQ    <= sink_imag;

            s2ValidQ <= s1ValidQ;
            s2SopQ   <= s1SopQ;
            s2EopQ   <= s1EopQ;
            s2ErrQ   <= s1ErrQ;
            s2ReQ    <= s1ReQ;
            s2ImQ    <= s1ImQ;

            s3ValidQ <= s2ValidQ;
            s3SopQ   <= s2SopQ;
            s3EopQ   <= s2EopQ;
            s3ErrQ   <= s2ErrQ;
            pRcQ     <= PW'(s2ReQ) * PW'(cosEff);
            pIsQ     <= PW'(s2ImQ) * PW'(sinEff);
            pIcQ     <= PW'(s2ImQ) * PW'(cosEff);
            pRsQ     <= PW'(s2ReQ) * PW'(sinEff);

            outValidQ <= s3ValidQ;
            outSopQ   <= s3SopQ;
            outEopQ   <= s3EopQ;
            outErrQ   <= s3ErrQ;
            outReQ    <= saturate(rndRe);
            outImQ    <= saturate(rndIm);
        end
    end

    assign sink_ready   = !stall;
    assign tw_addr      = twAddrQ;
    assign fftpts_out   = fftptsQ;
    assign source_valid = outValidQ;
    assign source_sop   = outSopQ;
    assign source_eop   = outEopQ;
    assign source_error = outErrQ;
    assign source_real  = outReQ;
    assign source_imag  = outImQ;
endmodule

// File: tb/tb_dct_postfft_twiddle.sv
// Scoreboard bench for dct_postfft_twiddle with a registered (1-cycle) twiddle ROM model.
`timescale 1ns/1ps
module tb_dct_postfft_twiddle;
    logic               clk = 1'b0;
    logic               rst_n;
    logic               sink_valid, sink_ready, sink_sop, sink_eop;
    logic [1:0]         sink_error;
    logic signed [15:0] sink_real, sink_imag;
    logic [11:0]        fftpts_in, fftpts_out;
    logic [10:0]        tw_addr;
    logic signed [15:0] tw_cos, tw_sin;
    logic               source_valid, source_ready, source_sop, source_eop;
    logic [1:0]         source_error;
    logic signed [15:0] source_real, source_imag;

    logic signed [15:0] romCos [2048];
    logic signed [15:0] romSin [2048];

    typedef struct {
        logic signed [15:0] re;
        logic signed [15:0] im;
        logic               sop;
        logic               eop;
        logic [1:0]         err;
    } exp_t;

    exp_t sbQ[$];
    exp_t monExp;
    int   checks = 0;
    int   failures = 0;

    dct_postfft_twiddle #(.wDataInOut(16), .wTw(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .sink_valid(sink_valid), .sink_ready(sink_ready), .sink_error(sink_error),
        .sink_sop(sink_sop), .sink_eop(sink_eop),
        .sink_real(sink_real), .sink_imag(sink_imag), .fftpts_in(fftpts_in),
        .tw_addr(tw_addr), .tw_cos(tw_cos), .tw_sin(tw_sin),
        .source_valid(source_valid), .source_ready(source_ready), .source_error(source_error),
        .source_sop(source_sop), .source_eop(source_eop),
        .source_real(source_real), .source_imag(source_imag), .fftpts_out(fftpts_out)
    );

    always #5 clk = ~clk;

    // Twiddle ROM: data appears one clock after the address.
    always @(posedge clk) begin
        tw_cos <= romCos[tw_addr];
        tw_sin <= romSin[tw_addr];
    end

    function automatic logic signed [15:0] satModel(input longint v);
        if (v > 32767) return 16'sd32767;
        if (v < -32768) return -16'sd32768;
        return 16'(v);
    endfunction

    function automatic logic signed [15:0] rotRe(input logic signed [15:0] xr, xi, c, s);
        longint acc;
        acc = longint'(xr) * longint'(c) + longint'(xi) * longint'(s);
        return satModel((acc + 64'sd16384) >>> 15);
    endfunction

    function automatic logic signed [15:0] rotIm(input logic signed [15:0] xr, xi, c, s);
        longint acc;
        acc = longint'(xi) * longint'(c) - longint'(xr) * longint'(s);
        return satModel((acc + 64'sd16384) >>> 15);
    endfunction

    // Output monitor: every transferred sample is popped from the scoreboard and compared.
    always @(negedge clk) begin
        if (rst_n && source_valid && source_ready) begin
            checks++;
            if (sbQ.size() == 0) begin
                failures++;
                $display("[TB] FAIL unexpectedOutput: got real=%0d imag=%0d with empty scoreboard, expected no output",
                         source_real, source_imag);
            end else begin
                monExp = sbQ.pop_front();
                if ({source_real, source_imag, source_sop, source_eop, source_error} !==
                    {monExp.re, monExp.im, monExp.sop, monExp.eop, monExp.err}) begin
                    failures++;
                    $display("[TB] FAIL outputSample: got re=%0d im=%0d sop=%0b eop=%0b err=%0b, expected re=%0d im=%0d sop=%0b eop=%0b err=%0b",
                             source_real, source_imag, source_sop, source_eop, source_error,
                             monExp.re, monExp.im, monExp.sop, monExp.eop, monExp.err);
                end
            end
        end
    end

    initial begin
        #1ms;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog");
    end

    // Present one sample, wait (bounded) for acceptance, check tw_addr and push the expected output.
    task automatic applyStimulus(input logic signed [15:0] xr, xi, input logic sop, eop,
                                 input logic [1:0] err, input logic [10:0] expK, input logic [1:0] expErr);
        logic acc = 1'b0;
        int   waited = 0;
        exp_t e;
        sink_valid = 1'b1; sink_real = xr; sink_imag = xi;
        sink_sop = sop; sink_eop = eop; sink_error = err;
        while (!acc) begin
            @(negedge clk);
            acc = sink_ready;
            @(posedge clk);
            #1;
            if (!acc) begin
                waited++;
                if (waited > 50) begin
                    checks++; failures++;
                    $display("[TB] FAIL acceptTimeout: got no accept in %0d cycles, expected accept", waited);
                    sink_valid = 1'b0;
                    return;
                end
            end
        end
        sink_valid = 1'b0;
        checks++;
        if (tw_addr !== expK) begin
            failures++;
            $display("[TB] FAIL twAddr: got %0d expected %0d", tw_addr, expK);
        end
        e.re = rotRe(xr, xi, romCos[expK], romSin[expK]);
        e.im = rotIm(xr, xi, romCos[expK], romSin[expK]);
        e.sop = sop; e.eop = eop; e.err = expErr;
        sbQ.push_back(e);
    endtask

    task automatic drain();
        int c = 0;
        while (sbQ.size() != 0 && c < 100) begin
            @(posedge clk);
            c++;
        end
        #1;
        checks++;
        if (sbQ.size() != 0) begin
            failures++;
            $display("[TB] FAIL drain: got %0d samples outstanding, expected 0", sbQ.size());
            sbQ.delete();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; sink_valid = 1'b0; sink_sop = 1'b0; sink_eop = 1'b0; sink_error = 2'b00;
        sink_real = '0; sink_imag = '0; fftpts_in = 12'd0; source_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({source_valid, source_sop, source_eop, source_error} !== 5'b0) begin
            failures++;
            $display("[TB] FAIL resetFlags: got %0b expected 0", {source_valid, source_sop, source_eop, source_error});
        end
        checks++;
        if (tw_addr !== 11'd0 || fftpts_out !== 12'd0 || source_real !== 16'sd0 || source_imag !== 16'sd0) begin
            failures++;
            $display("[TB] FAIL resetData: got addr=%0d pts=%0d re=%0d im=%0d expected all 0",
                     tw_addr, fftpts_out, source_real, source_imag);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (sink_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL readyAfterReset: got %0b expected 1", sink_ready);
        end
    endtask

    // Single-sample frame (sop and eop together) that also checks the 3-cycle latency.
    task automatic test_impulse();
        fftpts_in = 12'd2048;
        romCos[0] = 16'sd32767; romSin[0] = 16'sd0;
        applyStimulus(16'sd1000, 16'sd0, 1'b1, 1'b1, 2'b00, 11'd0, 2'b00);
        checks++;
        if (fftpts_out !== 12'd2048) begin
            failures++;
            $display("[TB] FAIL fftptsOut: got %0d expected 2048", fftpts_out);
        end
        repeat (2) begin @(posedge clk); #1; end
        checks++;
        if (source_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL latencyEarly: got valid=%0b expected 0", source_valid);
        end
        @(posedge clk); #1;
        checks++;
        if (source_valid !== 1'b1 || source_real !== 16'sd1000 || source_imag !== 16'sd0 || source_sop !== 1'b1) begin
            failures++;
            $display("[TB] FAIL impulse: got valid=%0b re=%0d im=%0d sop=%0b expected 1 1000 0 1",
                     source_valid, source_real, source_imag, source_sop);
        end
        applyStimulus(16'sd1000, 16'sd0, 1'b1, 1'b1, 2'b00, 11'd0, 2'b00);
        drain();
    endtask

    task automatic test_rotation_k1024();
        fftpts_in = 12'd2048;
        romCos[1024] = 16'sd23170; romSin[1024] = 16'sd23170;
        for (int i = 0; i < 1024; i++)
            applyStimulus(16'($urandom), 16'($urandom), i == 0, 1'b0, 2'b00, 11'(i), 2'b00);
        applyStimulus(16'sd100, 16'sd200, 1'b0, 1'b1, 2'b00, 11'd1024, 2'b00);
        repeat (3) begin @(posedge clk); #1; end
        checks++;
        if (source_real !== 16'sd212 || source_imag !== 16'sd71) begin
            failures++;
            $display("[TB] FAIL rotK1024: got re=%0d im=%0d expected re=212 im=71", source_real, source_imag);
        end
        drain();
    endtask

    task automatic test_saturation();
        fftpts_in = 12'd8;
        romCos[0] = 16'sd32767; romSin[0] = 16'sd32767;
        romCos[1] = 16'sd32767; romSin[1] = 16'sd32767;
        applyStimulus(16'sd32767, 16'sd32767, 1'b1, 1'b0, 2'b00, 11'd0, 2'b00);
        applyStimulus(-16'sd32768, -16'sd32768, 1'b0, 1'b1, 2'b00, 11'd1, 2'b00);
        repeat (2) begin @(posedge clk); #1; end
        checks++;
        if (source_real !== 16'sd32767) begin
            failures++;
            $display("[TB] FAIL satPos: got %0d expected 32767", source_real);
        end
        @(posedge clk); #1;
        checks++;
        if (source_real !== -16'sd32768) begin
            failures++;
            $display("[TB] FAIL satNeg: got %0d expected -32768", source_real);
        end
        drain();
    endtask

    task automatic test_backpressure();
        fftpts_in = 12'd16;
        fork
            begin
                for (int i = 0; i < 16; i++)
                    applyStimulus(16'($urandom), 16'($urandom), i == 0, i == 15, 2'b00, 11'(i), 2'b00);
            end
            begin
                logic signed [15:0] holdRe, holdIm;
                logic [10:0]        holdAddr;
                repeat (6) @(posedge clk);
                #1;
                source_ready = 1'b0;
                @(negedge clk);
                holdRe = source_real; holdIm = source_imag; holdAddr = tw_addr;
                for (int c = 0; c < 5; c++) begin
                    if (c != 0) @(negedge clk);
                    checks++;
                    if (sink_ready !== 1'b0) begin
                        failures++;
                        $display("[TB] FAIL stallReady: got %0b expected 0 in stall cycle %0d", sink_ready, c);
                    end
                    checks++;
                    if (source_real !== holdRe || source_imag !== holdIm || tw_addr !== holdAddr || source_valid !== 1'b1) begin
                        failures++;
                        $display("[TB] FAIL stallHold: got re=%0d im=%0d addr=%0d expected re=%0d im=%0d addr=%0d",
                                 source_real, source_imag, tw_addr, holdRe, holdIm, holdAddr);
                    end
                    @(posedge clk);
                    #1;
                end
                source_ready = 1'b1;
            end
        join
        drain();
    endtask

    task automatic test_back_to_back();
        fftpts_in = 12'd4;
        for (int f = 0; f < 2; f++)
            for (int i = 0; i < 4; i++)
                applyStimulus(16'($urandom), 16'($urandom), i == 0, i == 3, 2'b00, 11'(i), 2'b00);
        drain();
    endtask

    task automatic test_overlong_short();
        fftpts_in = 12'd8;
        for (int i = 0; i < 9; i++)
            applyStimulus(16'($urandom), 16'($urandom), i == 0, 1'b0, 2'b00, 11'(i % 8), (i == 8) ? 2'b01 : 2'b00);
        for (int i = 0; i < 4; i++)
            applyStimulus(16'($urandom), 16'($urandom), i == 0, i == 3, (i == 2) ? 2'b10 : 2'b00, 11'(i),
                          (i == 2) ? 2'b10 : 2'b00);
        applyStimulus(16'($urandom), 16'($urandom), 1'b0, 1'b0, 2'b00, 11'd0, 2'b00);
        drain();
    endtask

    task automatic test_reset_midframe();
        fftpts_in = 12'd16;
        for (int i = 0; i < 5; i++)
            applyStimulus(16'($urandom), 16'($urandom), i == 0, 1'b0, 2'b00, 11'(i), 2'b00);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({source_valid, source_sop, source_eop, source_error} !== 5'b0 || source_real !== 16'sd0 ||
            source_imag !== 16'sd0 || tw_addr !== 11'd0 || fftpts_out !== 12'd0) begin
            failures++;
            $display("[TB] FAIL asyncReset: got valid=%0b re=%0d im=%0d addr=%0d pts=%0d expected all 0",
                     source_valid, source_real, source_imag, tw_addr, fftpts_out);
        end
        sbQ.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++)
            applyStimulus(16'($urandom), 16'($urandom), i == 0, i == 3, 2'b00, 11'(i), 2'b00);
        drain();
        checks++;
        if (fftpts_out !== 12'd16) begin
            failures++;
            $display("[TB] FAIL fftptsAfterReset: got %0d expected 16", fftpts_out);
        end
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) begin
            romCos[i] = 16'($urandom);
            romSin[i] = 16'($urandom);
        end
        test_reset();
        test_impulse();
        test_rotation_k1024();
        test_saturation();
        test_backpressure();
        test_back_to_back();
        test_overlong_short();
        test_reset_midframe();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
